// File: rtl/cover_sched_pkg.sv
// Shared defaults and cover-index type for the toggle-coverage index scheduler.
package cover_sched_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 9;
    localparam int DEF_IDX_W   = 32;

    typedef logic [DEF_IDX_W-1:0] cover_idx_t;

endpackage

// File: rtl/cover_rr_arb.sv
// Combinational round-robin grant: first set request at or after ptr wins.
// Zero latency; an empty request vector yields an all-zero grant.
module cover_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cover_toggle_sched.sv
// Turns per-requester toggle hit vectors into a stream of cover indices (base + bit).
// Accept-to-out_valid is 2 edges; out_ready low freezes the output and stalls all pending work.
module cover_toggle_sched
    import cover_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int IDX_W   = DEF_IDX_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_bits,
    input  logic [NUM_REQ*IDX_W-1:0] req_base,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_index,
    output logic                     busy,
    output logic [31:0]              emit_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   pending [NUM_REQ];
    logic [IDX_W-1:0]   base    [NUM_REQ];
    logic [PTR_W-1:0]   ptr;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic [WIDTH-1:0]   grant_bits;
    logic [BIT_W-1:0]   bit_sel;
    logic               load;

    cover_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req   (eligible),
        .ptr   (ptr),
        .grant (grant)
    );

    // Ready looks at the registered pending value, so a slot whose last bit is
    // being cleared this cycle only reopens on the next one.
    always_comb begin
        eligible  = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i]  = |pending[i];
            req_ready[i] = reset & enable & ~eligible[i];
        end
    end

    always_comb begin
        grant_idx  = '0;
        grant_bits = '0;
        bit_sel    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx  = PTR_W'(i);
                grant_bits = pending[i];
            end
        end
        for (int b = WIDTH - 1; b >= 0; b--) begin
            if (grant_bits[b]) bit_sel = BIT_W'(b);
        end
    end

    assign load = (|eligible) & (~out_valid | out_ready);
    assign busy = reset & ((|eligible) | out_valid);

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                pending[i] <= '0;
                base[i]    <= '0;
            end
            ptr        <= '0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            emit_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    pending[i] <= req_bits[i*WIDTH +: WIDTH];
                    base[i]    <= req_base[i*IDX_W +: IDX_W];
                end else if (load && grant[i]) begin
                    pending[i][bit_sel] <= 1'b0;
                end
            end
            if (load) begin
                out_valid <= 1'b1;
                out_index <= base[grant_idx] + IDX_W'(bit_sel);
                ptr       <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) emit_count <= emit_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Directed bench for cover_toggle_sched with hand-computed expected indices.
module tb_cover_toggle_sched;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 9;
    localparam int IDX_W   = 32;

    logic                     clock;
    logic                     reset;
    logic                     enable;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_bits;
    logic [NUM_REQ*IDX_W-1:0] req_base;
    logic                     out_valid;
    logic                     out_ready;
    logic [IDX_W-1:0]         out_index;
    logic                     busy;
    logic [31:0]              emit_count;

    int n_checks = 0;
    int n_errors = 0;

    cover_toggle_sched #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .IDX_W   (IDX_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_bits   (req_bits),
        .req_base   (req_base),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .busy       (busy),
        .emit_count (emit_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] bits, input logic [IDX_W-1:0] b);
        req_valid[i]                = 1'b1;
        req_bits[i*WIDTH +: WIDTH]  = bits;
        req_base[i*IDX_W +: IDX_W]  = b;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        repeat (2) step();
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b1;
        req_valid = '0;
        req_bits  = '0;
        req_base  = '0;
        out_ready = 1'b1;
        repeat (2) step();
        check("rst_ready", req_ready, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_index", out_index, 32'd0);
        check("rst_count", emit_count, 32'd0);
        reset = 1'b1;
        #1;
        check("post_rst_ready", req_ready, 4'hF);

        // Two bits from one requester, full-rate sink.
        set_req(0, 9'b000000101, 32'd100);
        step();
        req_valid = '0;
        check("s1_accept_valid", out_valid, 1'b0);
        check("s1_accept_busy", busy, 1'b1);
        check("s1_accept_ready", req_ready[0], 1'b0);
        step();
        check("s1_first_valid", out_valid, 1'b1);
        check("s1_first_index", out_index, 32'd100);
        step();
        check("s1_second_index", out_index, 32'd102);
        check("s1_second_count", emit_count, 32'd1);
        check("s1_ready_back", req_ready[0], 1'b1);
        step();
        check("s1_drop_valid", out_valid, 1'b0);
        check("s1_final_count", emit_count, 32'd2);
        check("s1_idle_busy", busy, 1'b0);

        // Round-robin between two requesters accepted together.
        do_reset();
        set_req(0, 9'h001, 32'd0);
        set_req(1, 9'h003, 32'd50);
        step();
        req_valid = '0;
        step();
        check("s2_idx0", out_index, 32'd0);
        step();
        check("s2_idx1", out_index, 32'd50);
        step();
        check("s2_idx2", out_index, 32'd51);
        step();
        check("s2_drop_valid", out_valid, 1'b0);
        check("s2_count", emit_count, 32'd3);

        // Backpressure: output frozen, nothing lost.
        do_reset();
        out_ready = 1'b0;
        set_req(0, 9'b100010010, 32'd10);
        step();
        req_valid = '0;
        step();
        for (int c = 0; c < 5; c++) begin
            check("s3_hold_valid", out_valid, 1'b1);
            check("s3_hold_index", out_index, 32'd11);
            step();
        end
        check("s3_hold_count", emit_count, 32'd0);
        out_ready = 1'b1;
        step();
        check("s3_idx1", out_index, 32'd14);
        step();
        check("s3_idx2", out_index, 32'd18);
        step();
        check("s3_drop_valid", out_valid, 1'b0);
        check("s3_count", emit_count, 32'd3);

        // Index wrap-around.
        do_reset();
        set_req(2, 9'h002, 32'hFFFF_FFFF);
        step();
        req_valid = '0;
        step();
        check("s4_wrap_valid", out_valid, 1'b1);
        check("s4_wrap_index", out_index, 32'd0);

        // Enable low blocks acceptance while earlier work drains.
        do_reset();
        out_ready = 1'b0;
        set_req(0, 9'h003, 32'd200);
        step();
        req_valid = '0;
        enable    = 1'b0;
        set_req(1, 9'h001, 32'd300);
        #1;
        check("s5_ready_off", req_ready, 4'h0);
        step();
        check("s5_idx0", out_index, 32'd200);
        out_ready = 1'b1;
        step();
        check("s5_idx1", out_index, 32'd201);
        step();
        check("s5_drop_valid", out_valid, 1'b0);
        check("s5_not_accepted", busy, 1'b0);
        check("s5_count", emit_count, 32'd2);
        check("s5_ready_still_off", req_ready, 4'h0);
        req_valid = '0;
        enable    = 1'b1;
        #1;
        check("s5_ready_on", req_ready, 4'hF);

        // Reset mid-drain.
        do_reset();
        set_req(0, 9'h0F0, 32'd0);
        step();
        req_valid = '0;
        step();
        check("s6_first_index", out_index, 32'd4);
        step();
        reset = 1'b0;
        #1;
        check("s6_rst_ready_now", req_ready, 4'h0);
        step();
        check("s6_rst_valid", out_valid, 1'b0);
        check("s6_rst_busy", busy, 1'b0);
        check("s6_rst_count", emit_count, 32'd0);
        check("s6_rst_ready", req_ready, 4'h0);
        step();
        check("s6_rst_hold_ready", req_ready, 4'h0);
        check("s6_rst_hold_valid", out_valid, 1'b0);
        reset = 1'b1;
        step();
        check("s6_released_ready", req_ready, 4'hF);
        check("s6_released_valid", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
